pc_fetch_gen: RTL and testbench
===============================

// Module: pc_fetch_gen
// PURPOSE
//  Parametrised program-counter generator driving the instruction-fetch request port.
//  Successor to the fixed +4 PC: adds a configurable reset vector, step and width.
//  Also adds a valid/ready fetch handshake, branch/jump redirect with downstream kill,
//  stall, misaligned-target halt, and an accepted-fetch counter.
//  Sits between the branch-resolve stage and the memory controller / IF stage.
// PARAMETERS
//  ADDR_WIDTH    32  width of PC and request address
//  RESET_VECTOR  0   PC value loaded on reset
//  PC_STEP       4   increment applied per accepted fetch
//  ALIGN_BITS    2   low target bits that must be zero; 0 disables the check
//  CNT_WIDTH     16  width of the accepted-fetch counter
// PORTS
//  clk_in          in   1           clock; all state updates on posedge
//  rst_in          in   1           synchronous reset, active high
//  rdy_in          in   1           global ready; 0 freezes all state
//  stall_in        in   1           pipeline stall request from IF/ID
//  br_valid_in     in   1           redirect request, one-cycle pulse
//  br_target_in    in   ADDR_WIDTH  redirect target address
//  req_valid_out   out  1           fetch request valid
//  req_addr_out    out  ADDR_WIDTH  fetch address; equals pc_out
//  req_ready_in    in   1           memory controller accepts request
//  pc_out          out  ADDR_WIDTH  current PC register
//  kill_out        out  1           one-cycle pulse: discard all in-flight fetches
//  misalign_out    out  1           sticky: misaligned redirect seen, block halted
//  fetch_cnt_out   out  CNT_WIDTH   number of accepted fetches, wraps
// BEHAVIOUR
//  Reset (rst_in=1 at posedge; overrides rdy_in and all other inputs):
//   state=INIT, pc=RESET_VECTOR, kill_out=0, misalign_out=0, fetch_cnt_out=0.
//   req_valid_out=0 while in INIT.
//  Transfer occurs when req_valid_out && req_ready_in at a posedge.
//  req_valid_out = (state==RUN), decoded from registered state only (no comb path).
//  Priority each posedge: rst_in > !rdy_in > redirect > stall > advance.
//  rdy_in=0: state, pc and counter hold; redirect is ignored; kill_out forced 0.
//  States:
//   INIT : next posedge with rdy_in=1 -> RUN (one-cycle start bubble).
//          A redirect taken here loads pc; kill_out stays 0 (nothing in flight).
//   RUN  : aligned redirect -> pc<=br_target_in, kill_out=1 next cycle, stay RUN.
//          Misaligned redirect -> HALT, misalign_out<=1, pc holds.
//          Else if stall_in -> STALL; valid drops next cycle (stall may withdraw a request).
//          Else if transfer -> pc<=pc+PC_STEP, fetch_cnt+1.
//          Else (valid && !ready) -> pc holds; address stable until accepted.
//   STALL: redirect handled as in RUN, but state remains STALL. !stall_in -> RUN.
//   HALT : exited only by rst_in; redirect, stall and ready are ignored.
//  A transfer in the same cycle as a redirect still counts in fetch_cnt.
//   pc takes the target, not pc+PC_STEP; that fetch is covered by kill_out.
//  pc arithmetic is modulo 2^ADDR_WIDTH; pc+PC_STEP wraps to low addresses silently.
//  fetch_cnt wraps modulo 2^CNT_WIDTH.
//  kill_out is a registered 1-cycle pulse.
//   Back-to-back redirects give back-to-back kill pulses.
//  Misalignment = (br_target_in[ALIGN_BITS-1:0] != 0); never flagged when ALIGN_BITS=0.
// TESTING
//  Reset, then rdy=1, ready=1 held 4 cycles.
//   -> valid=0 in the first cycle; then addresses 0,4,8 are presented; fetch_cnt=3.
//  ready=0 for 3 cycles at pc=0x10.
//   -> addr held at 0x10, cnt unchanged; ready=1 -> next addr 0x14.
//  br_valid with target 0x100 while ready=1 at pc=0x20.
//   -> pc=0x100 next cycle, kill_out=1 for exactly 1 cycle, cnt+1.
//  br_valid with target 0x102 (ALIGN_BITS=2).
//   -> misalign_out=1, valid=0; further br and ready ignored until rst_in.
//  ADDR_WIDTH=8, pc=0xFC, ready=1 -> next pc=0x00; rdy_in=0 mid-run -> all outputs frozen.
//  stall_in=1 for 2 cycles while in RUN.
//   -> valid low, pc held; a br during the stall -> pc=target, kill pulse, resumes at target.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// rtl/pc_fetch_gen.sv - program-counter generator driving the instruction-fetch request port
module pc_fetch_gen #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    PC_STEP      = 4,
    parameter int                    ALIGN_BITS   = 2,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  stall_in,
    input  logic                  br_valid_in,
    input  logic [ADDR_WIDTH-1:0] br_target_in,
    output logic                  req_valid_out,
    output logic [ADDR_WIDTH-1:0] req_addr_out,
    input  logic                  req_ready_in,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  kill_out,
    output logic                  misalign_out,
    output logic [CNT_WIDTH-1:0]  fetch_cnt_out
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Zero mask when ALIGN_BITS=0, which disables the alignment check.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CNT_WIDTH-1:0]  fetch_cnt;
    logic                  kill;
    logic                  misalign;
    logic                  transfer;
    logic                  target_misaligned;

    assign req_valid_out     = (state == ST_RUN);
    assign req_addr_out      = pc;
    assign pc_out            = pc;
    assign kill_out          = kill;
    assign misalign_out      = misalign;
    assign fetch_cnt_out     = fetch_cnt;
    assign transfer          = req_valid_out && req_ready_in;
    assign target_misaligned = |(br_target_in & ALIGN_MASK);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= ST_INIT;
            pc        <= RESET_VECTOR;
            fetch_cnt <= '0;
            kill      <= 1'b0;
            misalign  <= 1'b0;
        end else if (!rdy_in) begin
            kill <= 1'b0;
        end else begin
            kill <= 1'b0;
            case (state)
                ST_INIT: begin
                    state <= ST_RUN;
                    if (br_valid_in) begin
                        pc <= br_target_in;
                    end
                end
                ST_RUN, ST_STALL: begin
                    if (br_valid_in) begin
                        if (target_misaligned) begin
                            state    <= ST_HALT;
                            misalign <= 1'b1;
                        end else begin
                            pc   <= br_target_in;
                            kill <= 1'b1;
                        end
                        // The fetch accepted alongside a redirect is real; kill covers it.
                        if (transfer) begin
                            fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
                        end
                    end else if (state == ST_RUN) begin
                        if (stall_in) begin
                            state <= ST_STALL;
                        end else if (transfer) begin
                            pc        <= pc + ADDR_WIDTH'(PC_STEP);
                            fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
                        end
                    end else if (!stall_in) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb/tb_pc_fetch_gen.sv - self-checking bench for pc_fetch_gen
module tb_pc_fetch_gen;

    localparam int CW = 4;

    logic        clk;
    logic        rst, rdy, stall, br, ready;
    logic [31:0] target;
    logic        valid, kill, mis;
    logic [31:0] addr, pc;
    logic [CW-1:0] cnt;

    pc_fetch_gen #(
        .ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .PC_STEP(4),
        .ALIGN_BITS(2), .CNT_WIDTH(CW)
    ) u_dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .stall_in(stall),
        .br_valid_in(br), .br_target_in(target),
        .req_valid_out(valid), .req_addr_out(addr), .req_ready_in(ready),
        .pc_out(pc), .kill_out(kill), .misalign_out(mis), .fetch_cnt_out(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst, rdy, stall, br, ready;
        logic [31:0] target;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_kill, e_mis;
        int          e_cnt;
    } vec_t;

    typedef enum int {M_INIT, M_RUN, M_STALL, M_HALT} mode_t;

    vec_t        tbl[$];
    int          checks = 0;
    int          failures = 0;
    mode_t       m_mode;
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_kill, m_mis;

    task automatic add(bit r, bit y, bit s, bit b, bit rd, logic [31:0] t,
                       bit ev, logic [31:0] ep, bit ek, bit em, int ec);
        vec_t v;
        v.rst = r; v.rdy = y; v.stall = s; v.br = b; v.ready = rd; v.target = t;
        v.e_valid = ev; v.e_pc = ep; v.e_kill = ek; v.e_mis = em; v.e_cnt = ec;
        tbl.push_back(v);
    endtask

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Reference: one posedge of the fetch generator, straight from the behavioural rules.
    task automatic model_step();
        bit accepted;
        if (rst) begin
            m_mode = M_INIT; m_pc = 0; m_cnt = 0; m_kill = 0; m_mis = 0;
        end else if (!rdy) begin
            m_kill = 0;
        end else begin
            accepted = (m_mode == M_RUN) && ready;
            m_kill = 0;
            if (m_mode == M_INIT) begin
                if (br) m_pc = target;
                m_mode = M_RUN;
            end else if (m_mode == M_RUN || m_mode == M_STALL) begin
                if (br) begin
                    if (target % 4 != 0) begin
                        m_mode = M_HALT;
                        m_mis = 1;
                    end else begin
                        m_pc = target;
                        m_kill = 1;
                    end
                    if (accepted) m_cnt = (m_cnt + 1) % (1 << CW);
                end else if (m_mode == M_RUN) begin
                    if (stall) m_mode = M_STALL;
                    else if (accepted) begin
                        m_pc = m_pc + 32'd4;
                        m_cnt = (m_cnt + 1) % (1 << CW);
                    end
                end else if (!stall) begin
                    m_mode = M_RUN;
                end
            end
        end
    endtask

    task automatic drive(bit r, bit y, bit s, bit b, bit rd, logic [31:0] t);
        rst = r; rdy = y; stall = s; br = b; ready = rd; target = t;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; rdy = 0; stall = 0; br = 0; ready = 0; target = 0;
        m_mode = M_INIT; m_pc = 0; m_cnt = 0; m_kill = 0; m_mis = 0;

        //  rst rdy stl br rdy target          valid pc            kill mis cnt
        add(1, 0, 0, 0, 0, 32'h0,            0, 32'h0,          0, 0, 0);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h0,          0, 0, 0);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h4,          0, 0, 1);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h8,          0, 0, 2);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'hC,          0, 0, 3);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h10,         0, 0, 4);
        add(0, 1, 0, 0, 0, 32'h0,            1, 32'h10,         0, 0, 4);
        add(0, 1, 0, 0, 0, 32'h0,            1, 32'h10,         0, 0, 4);
        add(0, 1, 0, 0, 0, 32'h0,            1, 32'h10,         0, 0, 4);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h14,         0, 0, 5);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h18,         0, 0, 6);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h1C,         0, 0, 7);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h20,         0, 0, 8);
        add(0, 1, 0, 1, 1, 32'h100,          1, 32'h100,        1, 0, 9);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h104,        0, 0, 10);
        add(0, 0, 1, 1, 1, 32'h200,          1, 32'h104,        0, 0, 10);
        add(0, 1, 1, 0, 1, 32'h0,            0, 32'h104,        0, 0, 10);
        add(0, 1, 1, 1, 1, 32'h300,          0, 32'h300,        1, 0, 10);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h300,        0, 0, 10);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h304,        0, 0, 11);
        add(0, 1, 0, 1, 0, 32'hFFFF_FFFC,    1, 32'hFFFF_FFFC,  1, 0, 11);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h0,          0, 0, 12);
        add(0, 1, 0, 1, 1, 32'h102,          0, 32'h0,          0, 1, 13);
        add(0, 1, 0, 1, 1, 32'h200,          0, 32'h0,          0, 1, 13);
        add(1, 1, 0, 0, 1, 32'h0,            0, 32'h0,          0, 0, 0);
        add(0, 1, 0, 1, 0, 32'h50,           1, 32'h50,         0, 0, 0);
        add(0, 1, 1, 1, 1, 32'h40,           1, 32'h40,         1, 0, 1);
        add(0, 1, 0, 1, 0, 32'h80,           1, 32'h80,         1, 0, 1);
        add(0, 1, 0, 0, 1, 32'h0,            1, 32'h84,         0, 0, 2);

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].stall, tbl[i].br, tbl[i].ready, tbl[i].target);
            chk("vec_valid", i, 32'(valid), 32'(tbl[i].e_valid));
            chk("vec_pc",    i, pc,         tbl[i].e_pc);
            chk("vec_addr",  i, addr,       tbl[i].e_pc);
            chk("vec_kill",  i, 32'(kill),  32'(tbl[i].e_kill));
            chk("vec_mis",   i, 32'(mis),   32'(tbl[i].e_mis));
            chk("vec_cnt",   i, 32'(cnt),   32'(tbl[i].e_cnt));
        end

        // Counter wrap: 18 accepted fetches from reset leave the 4-bit count at 2.
        drive(1, 1, 0, 0, 1, 32'h0);
        drive(0, 1, 0, 0, 1, 32'h0);
        for (int k = 0; k < 18; k++) drive(0, 1, 0, 0, 1, 32'h0);
        chk("cnt_wrap", 0, 32'(cnt), 32'd2);
        chk("pc_after_wrap", 0, pc, 32'd72);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 3) != 0, t);
            chk("rnd_valid", n, 32'(valid), 32'(m_mode == M_RUN));
            chk("rnd_pc",    n, pc,         m_pc);
            chk("rnd_addr",  n, addr,       m_pc);
            chk("rnd_kill",  n, 32'(kill),  32'(m_kill));
            chk("rnd_mis",   n, 32'(mis),   32'(m_mis));
            chk("rnd_cnt",   n, 32'(cnt),   32'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
